// File: rtl/fifo_rd_packer_if.sv
// Bundles the FIFO read port and the packed-word output of fifo_rd_packer.
// The master side is the packer; the slave side is the FIFO plus downstream sink.
interface fifo_rd_packer_if #(
    parameter int BYTE_W = 8,
    parameter int LANES  = 4
);
    logic                       empty_sig;
    logic [BYTE_W-1:0]          dout;
    logic                       rd_sig;
    logic                       flush;
    logic [BYTE_W*LANES-1:0]    word_out;
    logic [2:0]                 word_bytes;
    logic                       word_valid;
    logic                       word_ready;

    modport master (
        input  empty_sig, dout, flush, word_ready,
        output rd_sig, word_out, word_bytes, word_valid
    );

    modport slave (
        output empty_sig, dout, flush, word_ready,
        input  rd_sig, word_out, word_bytes, word_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Reads bytes from a one-cycle-latency FIFO and packs them little-endian into
// LANES-byte words; a flush pulse emits whatever partial word has been gathered.
module fifo_rd_packer #(
    parameter int BYTE_W = 8,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_packer_if.master  bus
);
    localparam int CNT_W = $clog2(LANES + 1);

    typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [CNT_W-1:0]           iss_cnt;
    logic [CNT_W-1:0]           cap_cnt;
    logic                       rd_pend;
    logic                       flush_pend;
    logic [BYTE_W*LANES-1:0]    word_q;

    logic                       rd_issue;
    logic                       last_issue;
    logic                       handshake;
    logic                       flush_clr;
    logic                       enter_hold;

    // rst gates the strobe so no FIFO byte is popped while the packer is being cleared
    assign rd_issue   = !rst && (state_q == FILL) && !bus.empty_sig &&
                        (iss_cnt < CNT_W'(LANES)) && !flush_pend;
    assign last_issue = rd_issue && (iss_cnt == CNT_W'(LANES - 1));
    assign handshake  = (state_q == HOLD) && bus.word_ready;
    assign enter_hold = (state_d == HOLD) && (state_q != HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        flush_clr = 1'b0;
        case (state_q)
            FILL: begin
                if (last_issue) begin
                    state_d = WAIT;
                end else if (flush_pend && rd_pend) begin
                    state_d = WAIT;
                end else if (flush_pend && (cap_cnt != '0)) begin
                    state_d = HOLD;
                end else if (flush_pend) begin
                    flush_clr = 1'b1;
                end
            end
            // The last outstanding byte (if any) lands during this single cycle
            WAIT: state_d = HOLD;
            HOLD: begin
                if (handshake) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // A flush seen while a word is held survives the handshake and acts in the next FILL
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else if (bus.flush) begin
            flush_pend <= 1'b1;
        end else if (enter_hold || flush_clr) begin
            flush_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_cnt <= '0;
            cap_cnt <= '0;
            rd_pend <= 1'b0;
            word_q  <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (handshake) begin
                iss_cnt <= '0;
                cap_cnt <= '0;
                word_q  <= '0;
            end else begin
                if (rd_issue) begin
                    iss_cnt <= iss_cnt + CNT_W'(1);
                end
                if (rd_pend) begin
                    cap_cnt <= cap_cnt + CNT_W'(1);
                    for (int i = 0; i < LANES; i++) begin
                        if (cap_cnt == CNT_W'(i)) begin
                            word_q[i*BYTE_W +: BYTE_W] <= bus.dout;
                        end
                    end
                end
            end
        end
    end

    assign bus.rd_sig     = rd_issue;
    assign bus.word_valid = (state_q == HOLD);
    assign bus.word_bytes = (state_q == HOLD) ? 3'(cap_cnt) : 3'd0;
    assign bus.word_out   = word_q;

endmodule
